// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB-lite master: transfer types, sizes, master
// states and the slave register map.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } mst_state_e;

    // Slave register file map (byte addresses)
    localparam logic [3:0] REG_BUFFER     = 4'h0;
    localparam logic [3:0] REG_STATUS     = 4'h4;
    localparam logic [3:0] REG_ERROR      = 4'h6;
    localparam logic [3:0] REG_OCCUPANCY  = 4'h8;
    localparam logic [3:0] REG_TX_CONTROL = 4'hC;
    localparam logic [3:0] REG_FLUSH      = 4'hD;

    // A command is legal when its size is defined and its address is
    // naturally aligned to that size.
    function automatic logic cmd_legal(input logic [1:0] size,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering: replicates write data across all lanes and extracts
// the addressed read lane, zero-extended.
module ahb_lane_steer
    import ahb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] hrdata,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    // Replicate and extract according to transfer size and low address bits
    always_comb begin
        wdata_rep = wdata;
        rdata_ext = hrdata;
        case (size)
            SIZE_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'b0, hrdata[{addr_lo, 3'b000} +: 8]};
            end
            SIZE_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'b0, hrdata[{addr_lo[1], 4'b0000} +: 16]};
            end
            default: begin
                wdata_rep = wdata;
                rdata_ext = hrdata;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-lite initiator: command handshake in, address
// phase, data phase, one-cycle response pulse out, with hready timeout.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic [31:0]       rsp_rdata,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        hsize,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mst_state_e        state_q, state_d;
    logic              hsel_q, hsel_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        hsize_q, hsize_d;
    logic              hwrite_q, hwrite_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;

    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;
    logic              timeout;

    // Lane steering works from the latched command, so it is valid for the
    // whole of ADDR and DATA regardless of what the command port does.
    ahb_lane_steer u_steer (
        .size      (hsize_q),
        .addr_lo   (haddr_q[1:0]),
        .wdata     (wdata_q),
        .hrdata    (hrdata),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign hsel      = hsel_q;
    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hsize     = hsize_q;
    assign hwrite    = hwrite_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

    // Timeout fires on the last permitted consecutive hready-low bus cycle
    assign timeout = (state_q != ST_IDLE) && !hready && (tmo_q == TMO_LAST);

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        state_d     = state_q;
        hsel_d      = hsel_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        if (state_q != ST_IDLE && !hready) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wdata_d = cmd_wdata;
                    if (!cmd_legal(cmd_size, cmd_addr[1:0])) begin
                        // Rejected locally: the bus never sees it
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        haddr_d  = cmd_addr;
                        hsize_d  = cmd_size;
                        hwrite_d = cmd_write;
                        hsel_d   = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_rep;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = hresp;
                    rsp_rdata_d = (hresp || hwrite_q) ? '0 : rdata_ext;
                    hsel_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (hresp) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    hsel_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the bus state would otherwise do
        if (timeout) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
            hsel_d      = 1'b0;
            htrans_d    = HTRANS_IDLE;
            state_d     = ST_IDLE;
        end
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule
